// File: rtl/crc16_decode_if.sv
// Bundle of the serial receive-side signals that connect the bit-level front end
// (unstuffer / EOP detector) to the packet decoder.
interface crc16_decode_if;
    // Front end -> decoder
    logic        pkt_start;
    logic        bit_in;
    logic        bit_valid;
    logic        eop;

    // Decoder -> consumer
    logic [71:0] pkt_out;
    logic        pkt_valid;
    logic        crc_ok;
    logic        len_err;
    logic        busy;

    // The front end drives the serial stream and observes the decoded result
    modport master (
        output pkt_start,
        output bit_in,
        output bit_valid,
        output eop,
        input  pkt_out,
        input  pkt_valid,
        input  crc_ok,
        input  len_err,
        input  busy
    );

    // The decoder consumes the serial stream and reports the decoded result
    modport slave (
        input  pkt_start,
        input  bit_in,
        input  bit_valid,
        input  eop,
        output pkt_out,
        output pkt_valid,
        output crc_ok,
        output len_err,
        output busy
    );
endinterface

// File: rtl/crc16_decode.sv
// Serial packet decoder: collects an 8-bit PID and 64 data bits into a
// 72-bit parallel word, runs the 16 trailing CRC bits plus the data through a
// USB CRC16 LFSR and checks the fixed residual once the EOP arrives.
// Early EOPs and overlong packets are reported as a one-cycle length error.
module crc16_decode (
    input  logic          clock,
    input  logic          reset_n,
    crc16_decode_if.slave bus
);

    localparam logic [15:0] LFSR_SEED    = 16'hFFFF;
    localparam logic [15:0] CRC_RESIDUAL = 16'h800D;
    localparam logic [6:0]  LAST_PID_BIT  = 7'd7;
    localparam logic [6:0]  LAST_DATA_BIT = 7'd71;
    localparam logic [6:0]  LAST_CRC_BIT  = 7'd87;
    localparam logic [6:0]  CNT_MAX       = 7'h7F;

    typedef enum logic [2:0] {
        IDLE,
        RECV_PID,
        RECV_DATA,
        RECV_CRC,
        WAIT_EOP,
        DONE
    } stateType;

    stateType    r_state;
    stateType    w_stateNext;

    logic [6:0]  r_bitCnt;
    logic [15:0] r_lfsr;
    logic [71:0] r_pkt;
    logic        r_lenErr;

    logic        w_restart;
    logic        w_accept;
    logic        w_lenErrSet;
    logic        w_inPayload;
    logic        w_inCrcSpan;
    logic [15:0] w_lfsrNext;
    logic        w_pktValid;

    // One step of the USB CRC16 LFSR (x^16 + x^15 + x^2 + 1), fed MSB-side
    function automatic logic [15:0] lfsrStep(input logic [15:0] state,
                                             input logic        din);
        logic        fb;
        logic [15:0] nxt;
        fb      = din ^ state[15];
        nxt     = {state[14:0], 1'b0};
        nxt[0]  = fb;
        nxt[2]  = state[1] ^ fb;
        nxt[15] = state[14] ^ fb;
        return nxt;
    endfunction

    // Datapath helpers: which accepted bits land in the SIPO and which clock the LFSR
    always_comb begin
        w_inPayload = (r_bitCnt <= LAST_DATA_BIT);
        w_inCrcSpan = (r_bitCnt > LAST_PID_BIT) && (r_bitCnt <= LAST_CRC_BIT);
        w_lfsrNext  = lfsrStep(r_lfsr, bus.bit_in);
    end

    // State register; pkt_start is handled as a next-state decision, reset wins over all
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic plus the per-cycle accept/restart/length-error strobes
    always_comb begin
        w_stateNext = r_state;
        w_restart   = 1'b0;
        w_accept    = 1'b0;
        w_lenErrSet = 1'b0;

        if (bus.pkt_start) begin
            w_stateNext = RECV_PID;
            w_restart   = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    w_stateNext = IDLE;
                end
                RECV_PID: begin
                    if (bus.eop) begin
                        w_stateNext = IDLE;
                        w_lenErrSet = 1'b1;
                    end else if (bus.bit_valid) begin
                        w_accept = 1'b1;
                        if (r_bitCnt == LAST_PID_BIT) begin
                            w_stateNext = RECV_DATA;
                        end
                    end
                end
                RECV_DATA: begin
                    if (bus.eop) begin
                        w_stateNext = IDLE;
                        w_lenErrSet = 1'b1;
                    end else if (bus.bit_valid) begin
                        w_accept = 1'b1;
                        if (r_bitCnt == LAST_DATA_BIT) begin
                            w_stateNext = RECV_CRC;
                        end
                    end
                end
                RECV_CRC: begin
                    if (bus.eop) begin
                        w_stateNext = IDLE;
                        w_lenErrSet = 1'b1;
                    end else if (bus.bit_valid) begin
                        w_accept = 1'b1;
                        if (r_bitCnt == LAST_CRC_BIT) begin
                            w_stateNext = WAIT_EOP;
                        end
                    end
                end
                WAIT_EOP: begin
                    if (bus.eop) begin
                        w_stateNext = DONE;
                    end else if (bus.bit_valid) begin
                        w_stateNext = IDLE;
                        w_lenErrSet = 1'b1;
                    end
                end
                DONE: begin
                    w_stateNext = IDLE;
                end
                default: begin
                    w_stateNext = IDLE;
                end
            endcase
        end
    end

    // Bit counter, SIPO shifter, CRC LFSR and the registered length-error pulse
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_bitCnt <= '0;
            r_lfsr   <= LFSR_SEED;
            r_pkt    <= '0;
            r_lenErr <= 1'b0;
        end else begin
            r_lenErr <= w_lenErrSet;
            if (w_restart) begin
                r_bitCnt <= '0;
                r_lfsr   <= LFSR_SEED;
            end else if (w_accept) begin
                if (r_bitCnt != CNT_MAX) begin
                    r_bitCnt <= r_bitCnt + 7'd1;
                end
                if (w_inPayload) begin
                    r_pkt <= {bus.bit_in, r_pkt[71:1]};
                end
                if (w_inCrcSpan) begin
                    r_lfsr <= w_lfsrNext;
                end
            end
        end
    end

    // Result strobes are decoded straight from DONE so they line up with the held packet
    always_comb begin
        w_pktValid    = (r_state == DONE);
        bus.pkt_valid = w_pktValid;
        bus.crc_ok    = w_pktValid && (r_lfsr == CRC_RESIDUAL);
        bus.len_err   = r_lenErr;
        bus.busy      = (r_state != IDLE);
        bus.pkt_out   = r_pkt;
    end

endmodule

// File: doc/crc16_decode.md
CRC16_DECODE -- requirements
Module: crc16_decode

Interface
REQ-001 The block SHALL have no parameters: packet width is fixed at 72 bits (8 PID + 64 data) plus 16 CRC bits.
REQ-002 clock  input  1  sole clock; all state updates on posedge.
REQ-003 reset_n  input  1  synchronous, active-low reset, sampled on posedge clock.
REQ-004 pkt_start  input  1  single-cycle pulse marking the start of a new packet; arrives before the first PID bit.
REQ-005 bit_in  input  1  received, unstuffed serial bit.
REQ-006 bit_valid  input  1  bit_in is valid this cycle; 0 means hold (stuffed bit removed).
REQ-007 eop  input  1  single-cycle end-of-packet pulse from the EOP detector.
REQ-008 pkt_out  output  72  recovered packet; bit i is the i-th bit received (PID in [7:0]).
REQ-009 pkt_valid  output  1  one-cycle pulse: pkt_out is stable and crc_ok is meaningful.
REQ-010 crc_ok  output  1  CRC residual check passed; valid only while pkt_valid=1.
REQ-011 len_err  output  1  one-cycle pulse: packet ended early or overran 88 bits.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, RECV_PID, RECV_DATA, RECV_CRC, WAIT_EOP and DONE.
REQ-014 pkt_start SHALL move any state to RECV_PID, clear bit_cnt to 0 and seed the LFSR to all ones; bit_valid in that same cycle SHALL be ignored.
REQ-015 In RECV_*, each accepted bit (bit_valid=1) SHALL increment bit_cnt by 1; bit_cnt is 7 bits and never wraps.
REQ-016 The first 72 accepted bits SHALL shift into a right-shift SIPO: each new bit enters [71] and the others shift toward [0].
REQ-017 PID bits (bit_cnt 0-7) SHALL NOT update the LFSR; bits 8-87 (data and CRC) SHALL each clock the LFSR exactly once.
REQ-018 LFSR update, using x0..x15 and fb = bit_in ^ x15:
  - x0 <= fb; x2 <= x1 ^ fb; x15 <= x14 ^ fb;
  - every other xk <= x(k-1).
REQ-019 Transitions:
  - RECV_PID -> RECV_DATA after bit 7;
  - RECV_DATA -> RECV_CRC after bit 71;
  - RECV_CRC -> WAIT_EOP after bit 87.
REQ-020 In WAIT_EOP, eop SHALL go to DONE; bit_valid=1 before eop SHALL pulse len_err and return to IDLE.
REQ-021 eop in RECV_PID, RECV_DATA or RECV_CRC SHALL pulse len_err the next cycle and return to IDLE, with no pkt_valid.
REQ-022 If eop and bit_valid are high in the same cycle, eop SHALL win and the bit SHALL be discarded.
REQ-023 DONE SHALL last one cycle:
  - pkt_valid=1;
  - crc_ok=1 iff {x15..x0} == 16'h800D (USB CRC16 residual);
  - then go to IDLE.
REQ-024 Latency: pkt_valid SHALL assert exactly 1 cycle after the accepting eop cycle.
REQ-025 In IDLE, bit_valid and eop SHALL be ignored.
REQ-026 pkt_out SHALL hold its value until the next pkt_start.
REQ-027 crc_ok SHALL be 0 whenever pkt_valid=0.

Reset
REQ-028 While reset_n=0 at a posedge:
  - state = IDLE; bit_cnt = 0; LFSR = 16'hFFFF; pkt_out = 0;
  - pkt_valid, crc_ok, len_err and busy all 0.
REQ-029 Reset asserted mid-packet SHALL abandon the packet with no pkt_valid or len_err pulse.

Verification
REQ-030 Loopback: feed the crc16_encode out_bit stream for pkt_in = 72'h0123456789ABCDEF_C3 with bit_valid=1 every cycle, then eop -> pkt_valid 1 cycle after eop, crc_ok=1, pkt_out=72'h0123456789ABCDEF_C3.
REQ-031 Same packet with data bit 20 flipped -> pkt_valid=1, crc_ok=0.
REQ-032 Same packet with bit_valid deasserted for 1-3 random cycles at 10 points, including the data/CRC boundary -> identical result to REQ-030.
REQ-033 eop after 50 bits -> len_err pulse, no pkt_valid, busy=0 next cycle; 89 bits before eop -> len_err.
REQ-034 pkt_start at bit 40, then a full good packet -> only the second packet reports pkt_valid=1, crc_ok=1.
REQ-035 reset_n=0 for one cycle at bit 30 -> all outputs 0, LFSR=16'hFFFF; a following good packet passes.
